// File: rtl/hazard_unit.sv
// -----------------------------------------------------------------------------
// hazard_unit
//
// Pipeline hazard controller that sits beside the ID stage. It keeps shadow
// copies of the destination tags in flight in EX and MEM and the remaining
// HI/LO busy time. From these it produces:
//   - registered EX-operand forwarding selects, aligned to the EX cycle
//   - stall controls for the PC and IF/ID
//   - flush controls for IF/ID and ID/EX
//
// Optional build macro:
//   HAZARD_STATS_EN adds three saturating stall/flush statistics counters.
//
// Ports:
//   i_clk            rising-edge clock
//   i_rst_n          synchronous active-low reset
//   i_id_valid       ID holds a real instruction
//   i_id_rs_addr     ID source register A
//   i_id_rt_addr     ID source register B
//   i_id_use_rs      instruction reads rs
//   i_id_use_rt      instruction reads rt
//   i_id_dst_addr    final destination register (rd/rt already selected)
//   i_id_reg_write   instruction writes the register file
//   i_id_mem_read    instruction is a load
//   i_id_muldiv_start instruction is mult/multu/div/divu
//   i_id_hilo_read   instruction is mfhi/mflo
//   i_ex_branch_taken branch/jump resolved taken in EX this cycle
//   o_fwd_a          EX operand A select (FWD_NO / FWD_MEM / FWD_WB)
//   o_fwd_b          EX operand B select
//   o_stall_pc       hold PC
//   o_stall_if_id    hold IF/ID register
//   o_flush_if_id    turn IF/ID into a bubble
//   o_flush_id_ex    load a bubble into ID/EX
//   o_muldiv_busy    HI/LO result not yet available
//   o_lu_stall_cnt   load-use stall cycles        (HAZARD_STATS_EN only)
//   o_hl_stall_cnt   HI/LO stall cycles           (HAZARD_STATS_EN only)
//   o_flush_cnt      branch flush cycles          (HAZARD_STATS_EN only)
// -----------------------------------------------------------------------------
module hazard_unit #(
  parameter int unsigned MULDIV_LATENCY = 4
`ifdef HAZARD_STATS_EN
  ,
  parameter int unsigned CNT_W = 16
`endif
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_id_valid,
  input  logic [4:0] i_id_rs_addr,
  input  logic [4:0] i_id_rt_addr,
  input  logic       i_id_use_rs,
  input  logic       i_id_use_rt,
  input  logic [4:0] i_id_dst_addr,
  input  logic       i_id_reg_write,
  input  logic       i_id_mem_read,
  input  logic       i_id_muldiv_start,
  input  logic       i_id_hilo_read,
  input  logic       i_ex_branch_taken,
  output logic [1:0] o_fwd_a,
  output logic [1:0] o_fwd_b,
  output logic       o_stall_pc,
  output logic       o_stall_if_id,
  output logic       o_flush_if_id,
  output logic       o_flush_id_ex,
  output logic       o_muldiv_busy
`ifdef HAZARD_STATS_EN
  ,
  output logic [CNT_W-1:0] o_lu_stall_cnt,
  output logic [CNT_W-1:0] o_hl_stall_cnt,
  output logic [CNT_W-1:0] o_flush_cnt
`endif
);

  // Forwarding select encodings (match the execute-stage operand mux).
  localparam logic [1:0] FWD_NO  = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b01;
  localparam logic [1:0] FWD_WB  = 2'b10;

  localparam logic [3:0] MD_LOAD = 4'(MULDIV_LATENCY);

  // EX shadow tag: {valid, dst, reg_write, mem_read}
  logic       r_ex_valid;
  logic [4:0] r_ex_dst;
  logic       r_ex_reg_write;
  logic       r_ex_mem_read;

  // MEM shadow tag. The load bit is not kept: once a load reaches MEM its
  // result is forwardable from WB, so it no longer causes a stall.
  logic       r_mem_valid;
  logic [4:0] r_mem_dst;
  logic       r_mem_reg_write;

  logic [1:0] r_fwd_a;
  logic [1:0] r_fwd_b;
  logic [3:0] r_md_cnt;

  logic       w_ex_match_rs;
  logic       w_ex_match_rt;
  logic       w_mem_match_rs;
  logic       w_mem_match_rt;
  logic       w_lu;
  logic       w_hl;
  logic       w_stall;
  logic       w_accept;
  logic [1:0] w_fwd_a_d;
  logic [1:0] w_fwd_b_d;
  logic [3:0] w_md_cnt_d;

  // ---------------------------------------------------------------------------
  // Tag matching; register $0 never carries a dependency.
  // ---------------------------------------------------------------------------
  assign w_ex_match_rs  = r_ex_valid & r_ex_reg_write & (r_ex_dst == i_id_rs_addr) &
                          (i_id_rs_addr != 5'd0);
  assign w_ex_match_rt  = r_ex_valid & r_ex_reg_write & (r_ex_dst == i_id_rt_addr) &
                          (i_id_rt_addr != 5'd0);
  assign w_mem_match_rs = r_mem_valid & r_mem_reg_write & (r_mem_dst == i_id_rs_addr) &
                          (i_id_rs_addr != 5'd0);
  assign w_mem_match_rt = r_mem_valid & r_mem_reg_write & (r_mem_dst == i_id_rt_addr) &
                          (i_id_rt_addr != 5'd0);

  // ---------------------------------------------------------------------------
  // Hazard detection
  // ---------------------------------------------------------------------------
  assign o_muldiv_busy = (r_md_cnt != 4'd0);

  assign w_lu = i_id_valid & r_ex_mem_read &
                ((i_id_use_rs & w_ex_match_rs) | (i_id_use_rt & w_ex_match_rt));

  assign w_hl = i_id_valid & o_muldiv_busy & (i_id_hilo_read | i_id_muldiv_start);

  // A taken branch discards the ID instruction, so it must never stall.
  assign w_stall  = (w_lu | w_hl) & ~i_ex_branch_taken;
  assign w_accept = i_id_valid & ~w_stall & ~i_ex_branch_taken;

  assign o_stall_pc    = w_stall;
  assign o_stall_if_id = w_stall;
  assign o_flush_if_id = i_ex_branch_taken;
  assign o_flush_id_ex = w_stall | i_ex_branch_taken;

  assign o_fwd_a = r_fwd_a;
  assign o_fwd_b = r_fwd_b;

  // EX match wins over MEM match: the younger producer holds the live value.
  function automatic logic [1:0] fwd_sel(input logic use_src, input logic ex_match,
                                         input logic mem_match);
    logic [1:0] sel;
    sel = FWD_NO;
    if (use_src) begin
      if (ex_match) begin
        sel = FWD_MEM;
      end else if (mem_match) begin
        sel = FWD_WB;
      end
    end
    return sel;
  endfunction

  always_comb begin
    w_fwd_a_d = FWD_NO;
    w_fwd_b_d = FWD_NO;
    if (w_accept) begin
      w_fwd_a_d = fwd_sel(i_id_use_rs, w_ex_match_rs, w_mem_match_rs);
      w_fwd_b_d = fwd_sel(i_id_use_rt, w_ex_match_rt, w_mem_match_rt);
    end
  end

  // Busy counter keeps running through stalls and flushes; only an accepted
  // mult/div reloads it, so a flushed one never starts the unit.
  always_comb begin
    w_md_cnt_d = r_md_cnt;
    if (w_accept && i_id_muldiv_start) begin
      w_md_cnt_d = MD_LOAD;
    end else if (r_md_cnt != 4'd0) begin
      w_md_cnt_d = r_md_cnt - 4'd1;
    end
  end

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_ex_valid      <= 1'b0;
      r_ex_dst        <= 5'd0;
      r_ex_reg_write  <= 1'b0;
      r_ex_mem_read   <= 1'b0;
      r_mem_valid     <= 1'b0;
      r_mem_dst       <= 5'd0;
      r_mem_reg_write <= 1'b0;
      r_fwd_a         <= FWD_NO;
      r_fwd_b         <= FWD_NO;
      r_md_cnt        <= 4'd0;
    end else begin
      // Downstream never stalls: MEM always takes whatever was in EX.
      r_mem_valid     <= r_ex_valid;
      r_mem_dst       <= r_ex_dst;
      r_mem_reg_write <= r_ex_reg_write;
      if (w_accept) begin
        r_ex_valid     <= 1'b1;
        r_ex_dst       <= i_id_dst_addr;
        r_ex_reg_write <= i_id_reg_write;
        r_ex_mem_read  <= i_id_mem_read;
      end else begin
        r_ex_valid     <= 1'b0;
        r_ex_dst       <= 5'd0;
        r_ex_reg_write <= 1'b0;
        r_ex_mem_read  <= 1'b0;
      end
      r_fwd_a  <= w_fwd_a_d;
      r_fwd_b  <= w_fwd_b_d;
      r_md_cnt <= w_md_cnt_d;
    end
  end

`ifdef HAZARD_STATS_EN
  // ---------------------------------------------------------------------------
  // Saturating statistics. A cycle is attributed to one cause only: a taken
  // branch overrides both stalls, and load-use takes precedence over HI/LO.
  // ---------------------------------------------------------------------------
  logic [CNT_W-1:0] r_lu_cnt;
  logic [CNT_W-1:0] r_hl_cnt;
  logic [CNT_W-1:0] r_flush_cnt;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_lu_cnt    <= '0;
      r_hl_cnt    <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (w_lu && !i_ex_branch_taken && (r_lu_cnt != '1)) begin
        r_lu_cnt <= r_lu_cnt + 1'b1;
      end
      if (w_hl && !w_lu && !i_ex_branch_taken && (r_hl_cnt != '1)) begin
        r_hl_cnt <= r_hl_cnt + 1'b1;
      end
      if (i_ex_branch_taken && (r_flush_cnt != '1)) begin
        r_flush_cnt <= r_flush_cnt + 1'b1;
      end
    end
  end

  assign o_lu_stall_cnt = r_lu_cnt;
  assign o_hl_stall_cnt = r_hl_cnt;
  assign o_flush_cnt    = r_flush_cnt;
`endif

endmodule

// File: doc/hazard_unit.md
Name: hazard_unit

Overview:
- Pipeline control block that produces the forwarding selects `fwd_a`/`fwd_b` consumed by the execute stage.
- Also drives the stall and flush controls for IF/ID/EX.
- Keeps a private shadow of the destination tags in flight in EX and MEM, the outstanding multiply/divide latency, and registered forwarding decisions aligned to the EX cycle.
- Sits beside the ID stage; its outputs feed PC, IF/ID, ID/EX and the EX operand muxes.

Parameters:
- MULDIV_LATENCY, 4: cycles the HI/LO unit stays busy after a mult/div issues (1..15).
- CNT_W, 16: width of the stall statistics counters (only with the optional feature).

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous active-low reset
- id_valid  in  1  ID holds a real instruction
- id_rs_addr  in  5  ID source register A
- id_rt_addr  in  5  ID source register B
- id_use_rs  in  1  instruction reads rs
- id_use_rt  in  1  instruction reads rt
- id_dst_addr  in  5  final destination (rd or rt already selected)
- id_reg_write  in  1  instruction writes the register file
- id_mem_read  in  1  instruction is a load
- id_muldiv_start  in  1  instruction is mult/multu/div/divu
- id_hilo_read  in  1  instruction is mfhi/mflo
- ex_branch_taken  in  1  branch/jump resolved taken in EX this cycle
- fwd_a  out  2  EX operand A select (`FWD_NO`/`FWD_MEM`/`FWD_WB` from defines.v)
- fwd_b  out  2  EX operand B select
- stall_pc  out  1  hold PC
- stall_if_id  out  1  hold IF/ID register
- flush_if_id  out  1  turn IF/ID into a bubble
- flush_id_ex  out  1  load a bubble into ID/EX
- muldiv_busy  out  1  HI/LO result not yet available

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - EX/MEM shadow tags invalid; fwd_a=fwd_b=`FWD_NO`; muldiv counter=0.
  - All stall/flush outputs are combinational and read 0 while the tags are invalid and the inputs are idle.
  - Reset mid-stall or mid-muldiv abandons the operation immediately.
- Shadow tag format: {valid, dst_addr, reg_write, mem_read}. A tag "matches" source S when valid & reg_write & dst_addr==S & S!=0.
- Every cycle: MEM tag <= EX tag. Downstream never stalls.
- Load-use (combinational):
  - lu = id_valid & EX tag.mem_read & ((id_use_rs & EX match rs) | (id_use_rt & EX match rt)).
- HI/LO hazard (combinational):
  - hl = id_valid & muldiv_busy & (id_hilo_read | id_muldiv_start).
- stall = (lu | hl) & !ex_branch_taken:
  - stall_pc = stall_if_id = stall.
  - flush_id_ex = stall | ex_branch_taken.
- flush_if_id = ex_branch_taken. Branch beats stall: the wrong-path ID instruction is discarded and never stalls.
- Issue when accepted = id_valid & !stall & !ex_branch_taken:
  - EX tag <= ID info.
  - fwd_x <= `FWD_MEM` if the current EX tag matches the source.
  - Otherwise fwd_x <= `FWD_WB` if the current MEM tag matches.
  - Otherwise `FWD_NO`.
  - EX-tag priority over MEM-tag, because the younger result wins.
  - Source not used -> `FWD_NO`.
- Not accepted: EX tag <= invalid; fwd_a=fwd_b <= `FWD_NO`.
- fwd outputs are registered, so they are valid during the instruction's EX cycle. Latency is 1 cycle from ID.
- A load followed by a dependent instruction costs exactly 1 bubble; the dependent instruction then gets `FWD_WB`.
- muldiv counter:
  - Loaded with MULDIV_LATENCY when an accepted instruction has id_muldiv_start.
  - Otherwise decrements when nonzero; saturates at 0.
  - Keeps counting during stalls and flushes.
  - muldiv_busy = (counter != 0).
- A flushed mult/div never starts the counter.

Optional Feature:
- HAZARD_STATS_EN defined adds outputs `lu_stall_cnt` [CNT_W], `hl_stall_cnt` [CNT_W] and `flush_cnt` [CNT_W].
  - Each increments by 1 per cycle that its condition caused stall/flush: lu & !ex_branch_taken, hl & !lu & !ex_branch_taken, and ex_branch_taken respectively.
  - Counters saturate at all-ones and clear on reset.
- Undefined: the ports and counters are absent; all other behaviour is identical.

Test Plan:
- `add $3,$1,$2` then `sub $4,$3,$5` back-to-back -> sub's EX cycle sees fwd_a=`FWD_MEM`, fwd_b=`FWD_NO`, no stall.
- `add $3..`, `nop`, `or $6,$0,$3` -> or's EX cycle fwd_b=`FWD_WB`.
- `lw $3`, then `add $4,$3,$3`:
  - 1 cycle of stall_pc=stall_if_id=flush_id_ex=1.
  - Then add issues with fwd_a=fwd_b=`FWD_WB`.
- Writes to $0 followed by a reader of $0 -> fwd stays `FWD_NO`; two back-to-back writers of $7 then a reader -> `FWD_MEM`.
- `mult` with MULDIV_LATENCY=4, then `mflo` immediately -> mflo stalls 4 cycles, muldiv_busy falls in the same cycle the stall releases; assert rst_n=0 mid-count -> busy=0 next cycle.
- lw-use hazard with ex_branch_taken=1 in the same cycle -> stall=0, flush_if_id=flush_id_ex=1; with HAZARD_STATS_EN, flush_cnt=1 and lu_stall_cnt=0.
